demod_ctrl_seq: RTL

Start-up and run-time sequencer for the two-channel ADC → CIC decimator → demodulator chain.
- Holds the CIC decimators in reset until the clock wizard is locked and the decimators have been flushed.
- Generates the decimation-phase strobe.
- Masks demodulator output validity during warm-up and sustained ADC over-range.
- Sits beside the ADC controller and drives the CIC reset/enable and the demodulator valid qualifier.

---
 rtl/demod_ctrl_seq_pkg.sv | 22 ++
 rtl/demod_ctrl_seq_sync_2ff.sv | 25 ++
 rtl/demod_ctrl_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/demod_ctrl_seq_pkg.sv
// Shared types and defaults for the demodulator start-up sequencer.
package demod_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FLUSH     = 3'd1,
    WARMUP    = 3'd2,
    RUN       = 3'd3,
    OVR       = 3'd4
  } ctrl_state_e;

  localparam int unsigned DECIM_DEF        = 10;
  localparam int unsigned FLUSH_CYCLES_DEF = 16;
  localparam int unsigned WARMUP_OUT_DEF   = 4;
  localparam int unsigned OVR_LIMIT_DEF    = 8;

  // The CIC is out of reset and clocking in these states.
  function automatic logic cic_running(ctrl_state_e s);
    return (s == WARMUP) || (s == RUN) || (s == OVR);
  endfunction

endpackage

// File: rtl/demod_ctrl_seq_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (clock-wizard lock).
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the async level, then resolve metastability in a second stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/demod_ctrl_seq.sv
// Start-up / run-time sequencer for the ADC -> CIC -> demodulator chain.
// Holds the CIC in reset until lock + flush, generates the decimation strobe,
// and qualifies demodulator output around warm-up and sustained over-range.
// Optional macro OVR_AUTO_RESTART_EN: over-range recovery re-flushes the CIC
// instead of resuming RUN directly.
module demod_ctrl_seq
  import demod_ctrl_pkg::*;
#(
  parameter int unsigned DECIM        = DECIM_DEF,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned WARMUP_OUT   = WARMUP_OUT_DEF,
  parameter int unsigned OVR_LIMIT    = OVR_LIMIT_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_ADC_6MHz,
  input  logic             sys_rst_n,
  input  logic             locked,
  input  logic             restart,
  input  logic             ad1_otr,
  input  logic             ad2_otr,
  input  logic             ovr_clr,
  output logic             cic_rst,
  output logic             cic_en,
  output logic             dec_strobe,
  output logic             demod_valid,
  output logic [2:0]       state,
  output logic             ovr_flag,
  output logic [CNT_W-1:0] ovr_count
);

  localparam int unsigned PH_W = $clog2(DECIM + 1);
  localparam int unsigned FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WU_W = $clog2(WARMUP_OUT + 1);
  localparam int unsigned OV_W = $clog2(OVR_LIMIT + 1);

  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(DECIM - 1);
  localparam logic [PH_W-1:0]  PH_ONE  = PH_W'(1);
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [FL_W-1:0]  FL_ONE  = FL_W'(1);
  localparam logic [WU_W-1:0]  WU_LAST = WU_W'(WARMUP_OUT - 1);
  localparam logic [WU_W-1:0]  WU_ONE  = WU_W'(1);
  localparam logic [OV_W-1:0]  OV_LIM  = OV_W'(OVR_LIMIT);
  localparam logic [OV_W-1:0]  OV_ONE  = OV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ctrl_state_e      state_q, state_d;
  logic             lock_s;
  logic             otr_q;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [FL_W-1:0]  flush_q, flush_d;
  logic [WU_W-1:0]  wcnt_q, wcnt_d;
  logic [OV_W-1:0]  trip_q, trip_d;
  logic [OV_W-1:0]  clean_q, clean_d;

  logic             cic_rst_d, cic_en_d, dec_strobe_d, demod_valid_d;
  logic             ovr_flag_d;
  logic [CNT_W-1:0] ovr_count_d;
  logic             keep_run, enter_flush, trip_evt;

  sync_2ff u_lock_sync (
    .clk_i  (clk_ADC_6MHz),
    .rst_ni (sys_rst_n),
    .d_i    (locked),
    .q_o    (lock_s)
  );

  // State register.
  always_ff @(posedge clk_ADC_6MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= WAIT_LOCK;
    else            state_q <= state_d;
  end

  // Next state: lock loss, then restart, then over-range, then progression.
  always_comb begin
    state_d = state_q;
    trip_d  = '0;
    clean_d = '0;
    if (state_q == RUN && otr_q)  trip_d  = trip_q + OV_ONE;
    if (state_q == OVR && !otr_q) clean_d = clean_q + OV_ONE;

    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
    end else if (state_q != WAIT_LOCK && restart) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        WAIT_LOCK: if (lock_s) state_d = FLUSH;
        FLUSH:     if (flush_q == FL_LAST) state_d = WARMUP;
        WARMUP:    if (phase_q == PH_LAST && wcnt_q == WU_LAST) state_d = RUN;
        RUN:       if (trip_d == OV_LIM) state_d = OVR;
        OVR: begin
          if (clean_d == OV_LIM) begin
`ifdef OVR_AUTO_RESTART_EN
            state_d = FLUSH;
`else
            state_d = RUN;
`endif
          end
        end
        default:   state_d = WAIT_LOCK;
      endcase
    end
  end

  // Output and counter decode; outputs follow the state being entered so
  // they line up with the registered state.
  always_comb begin
    keep_run    = cic_running(state_q) && cic_running(state_d);
    enter_flush = (state_d == FLUSH) && ((state_q != FLUSH) || restart);
    trip_evt    = (state_q == RUN) && (state_d == OVR);

    flush_d = '0;
    if (state_d == FLUSH && !enter_flush) flush_d = flush_q + FL_ONE;

    phase_d = '0;
    if (keep_run) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;

    wcnt_d = '0;
    if (state_q == WARMUP && state_d == WARMUP)
      wcnt_d = (phase_q == PH_LAST) ? wcnt_q + WU_ONE : wcnt_q;

    cic_en_d      = cic_running(state_d);
    cic_rst_d     = !cic_running(state_d);
    demod_valid_d = (state_d == RUN);
    dec_strobe_d  = keep_run && (phase_q == PH_LAST);

    // A trip wins over a coincident clear: flag set, count restarts at 1.
    ovr_flag_d  = ovr_flag;
    ovr_count_d = ovr_count;
    if (trip_evt) begin
      ovr_flag_d  = 1'b1;
      ovr_count_d = ovr_clr ? CNT_ONE :
                    (&ovr_count) ? ovr_count : ovr_count + CNT_ONE;
    end else if (ovr_clr) begin
      ovr_flag_d  = 1'b0;
      ovr_count_d = '0;
    end
  end

  // Counters, over-range sample register and registered outputs.
  always_ff @(posedge clk_ADC_6MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      otr_q       <= 1'b0;
      phase_q     <= '0;
      flush_q     <= '0;
      wcnt_q      <= '0;
      trip_q      <= '0;
      clean_q     <= '0;
      cic_rst     <= 1'b1;
      cic_en      <= 1'b0;
      dec_strobe  <= 1'b0;
      demod_valid <= 1'b0;
      ovr_flag    <= 1'b0;
      ovr_count   <= '0;
    end else begin
      otr_q       <= ad1_otr | ad2_otr;
      phase_q     <= phase_d;
      flush_q     <= flush_d;
      wcnt_q      <= wcnt_d;
      trip_q      <= trip_d;
      clean_q     <= clean_d;
      cic_rst     <= cic_rst_d;
      cic_en      <= cic_en_d;
      dec_strobe  <= dec_strobe_d;
      demod_valid <= demod_valid_d;
      ovr_flag    <= ovr_flag_d;
      ovr_count   <= ovr_count_d;
    end
  end

  assign state = state_q;

endmodule
